// File: rtl/reset_seq_pkg.sv
// Shared types and sizing helpers for the staged reset release sequencer.
// Holds the FSM state encoding and the timer width calculation.
package reset_seq_pkg;

    typedef enum logic [1:0] {
        ST_ASSERT,
        ST_RELEASE,
        ST_RUN
    } seq_state_e;

    // Wide enough to hold the larger of the two terminal counts without wrapping.
    function automatic int cnt_width(input int min_assert, input int stage_gap);
        int m;
        m = (min_assert > stage_gap) ? min_assert : stage_gap;
        return (m < 1) ? 1 : $clog2(m + 1);
    endfunction

endpackage

// File: rtl/reset_seq_timer.sv
// Saturating up-counter with synchronous clear, restart and terminal-count compare.
// A restart loads 1 so the restarting cycle itself counts as the first elapsed cycle.
module reset_seq_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         clr_i,
    input  logic         start_i,
    input  logic [W-1:0] tc_val_i,
    output logic         tc_o
);

    localparam logic [W-1:0] CNT_MAX = '1;

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (start_i) begin
            count_d = W'(1);
        end else if (count_q != CNT_MAX) begin
            count_d = count_q + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (clr_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign tc_o = (count_q >= tc_val_i);

endmodule

// File: rtl/reset_release_sequencer.sv
// Holds all downstream reset stages for a minimum width, then releases them in
// index order with a fixed gap; a software request restarts the whole sequence.
module reset_release_sequencer
    import reset_seq_pkg::*;
#(
    parameter int NUM_STAGES = 3,
    parameter int MIN_ASSERT = 16,
    parameter int STAGE_GAP  = 8
) (
    input  logic                  clk,
    input  logic                  sync_rst_i,
    input  logic                  sw_rst_req_i,
    output logic                  sw_rst_ack_o,
    output logic [NUM_STAGES-1:0] stage_rst_o,
    output logic                  all_released_o,
    output logic                  busy_o
);

    localparam int CNT_W = cnt_width(MIN_ASSERT, STAGE_GAP);
    localparam int IDX_W = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;

    localparam logic [CNT_W-1:0] MA_CNT   = CNT_W'(MIN_ASSERT);
    localparam logic [CNT_W-1:0] GAP_CNT  = CNT_W'(STAGE_GAP);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_STAGES - 1);

    seq_state_e            state_q, state_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [NUM_STAGES-1:0] stage_q, stage_d;
    logic                  ack_q, ack_d;
    logic                  all_rel_q, all_rel_d;

    logic                  timer_start;
    logic [CNT_W-1:0]      tc_val;
    logic                  tc;

    reset_seq_timer #(
        .W (CNT_W)
    ) u_timer (
        .clk      (clk),
        .clr_i    (sync_rst_i),
        .start_i  (timer_start),
        .tc_val_i (tc_val),
        .tc_o     (tc)
    );

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        stage_d     = stage_q;
        ack_d       = 1'b0;
        timer_start = 1'b0;
        tc_val      = (state_q == ST_ASSERT) ? MA_CNT : GAP_CNT;

        if (sw_rst_req_i) begin
            // A request aborts whatever is in flight and restarts from a full assert window.
            state_d     = ST_ASSERT;
            idx_d       = '0;
            stage_d     = '1;
            ack_d       = 1'b1;
            timer_start = 1'b1;
        end else begin
            unique case (state_q)
                ST_ASSERT: begin
                    if (tc) begin
                        stage_d[0]  = 1'b0;
                        timer_start = 1'b1;
                        if (NUM_STAGES == 1) begin
                            state_d = ST_RUN;
                        end else begin
                            state_d = ST_RELEASE;
                            idx_d   = IDX_W'(1);
                        end
                    end
                end
                ST_RELEASE: begin
                    if (tc) begin
                        for (int i = 0; i < NUM_STAGES; i++) begin
                            if (idx_q == IDX_W'(i)) begin
                                stage_d[i] = 1'b0;
                            end
                        end
                        timer_start = 1'b1;
                        if (idx_q == LAST_IDX) begin
                            state_d = ST_RUN;
                        end else begin
                            idx_d = idx_q + IDX_W'(1);
                        end
                    end
                end
                ST_RUN: begin
                end
                default: begin
                    state_d = ST_ASSERT;
                end
            endcase
        end

        all_rel_d = (state_d == ST_RUN);
    end

    always_ff @(posedge clk) begin
        if (sync_rst_i) begin
            state_q   <= ST_ASSERT;
            idx_q     <= '0;
            stage_q   <= '1;
            ack_q     <= 1'b0;
            all_rel_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            stage_q   <= stage_d;
            ack_q     <= ack_d;
            all_rel_q <= all_rel_d;
        end
    end

    assign stage_rst_o    = stage_q;
    assign sw_rst_ack_o   = ack_q;
    assign all_released_o = all_rel_q;
    assign busy_o         = ~all_rel_q;

endmodule
